// File: rtl/cordic_pkg.sv
// Shared constants and types for the rolled CORDIC cosine unit.
// Contents:
//   IterDefault, FracDefault, IwDefault - default datapath sizing (16 rotations, Q3.22, 26 bits)
//   IdxW     - width of the micro-rotation index
//   KConst   - CORDIC gain compensation 1/An in Q3.22, used as the initial x
//   atan_q22 - atan(2^-i) in Q3.22 for i = 0..23
//   state_e  - controller state encoding
package cordic_pkg;

  localparam int unsigned IterDefault = 16;
  localparam int unsigned FracDefault = 22;
  localparam int unsigned IwDefault   = 26;
  localparam int unsigned IdxW        = 5;

  // round(0.6072529350 * 2^22)
  localparam logic signed [IwDefault-1:0] KConst = 26'sd2547003;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRot,
    StNorm
  } state_e;

  // Table values assume a 22-bit fraction.
  function automatic logic [IwDefault-1:0] atan_q22(input logic [IdxW-1:0] idx);
    logic [IwDefault-1:0] val;
    val = '0;
    case (idx)
      5'd0:  val = 26'd3294199;
      5'd1:  val = 26'd1944679;
      5'd2:  val = 26'd1027515;
      5'd3:  val = 26'd521583;
      5'd4:  val = 26'd261803;
      5'd5:  val = 26'd131029;
      5'd6:  val = 26'd65531;
      5'd7:  val = 26'd32767;
      5'd8:  val = 26'd16384;
      5'd9:  val = 26'd8192;
      5'd10: val = 26'd4096;
      5'd11: val = 26'd2048;
      5'd12: val = 26'd1024;
      5'd13: val = 26'd512;
      5'd14: val = 26'd256;
      5'd15: val = 26'd128;
      5'd16: val = 26'd64;
      5'd17: val = 26'd32;
      5'd18: val = 26'd16;
      5'd19: val = 26'd8;
      5'd20: val = 26'd4;
      5'd21: val = 26'd2;
      5'd22: val = 26'd1;
      default: val = '0;  // atan(2^-23) rounds to zero
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One rotation-mode CORDIC micro-rotation, purely combinational.
// Ports:
//   x_i, y_i, z_i - current vector and residual angle (signed fixed point)
//   idx_i         - micro-rotation index i (shift amount and atan table address)
//   x_o, y_o, z_o - vector and residual angle after the rotation
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned IW = IwDefault
) (
  input  logic signed [IW-1:0]   x_i,
  input  logic signed [IW-1:0]   y_i,
  input  logic signed [IW-1:0]   z_i,
  input  logic        [IdxW-1:0] idx_i,
  output logic signed [IW-1:0]   x_o,
  output logic signed [IW-1:0]   y_o,
  output logic signed [IW-1:0]   z_o
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;
  logic signed [IW-1:0] ang;

  always_comb begin
    x_sh = x_i >>> idx_i;
    y_sh = y_i >>> idx_i;
    ang  = IW'(atan_q22(idx_i));
    // Rotate towards z = 0: d = +1 when z >= 0
    if (!z_i[IW-1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - ang;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + ang;
    end
  end

endmodule

// File: rtl/cordic_cos_iter.sv
// Cosine custom-instruction slave: IEEE-754 single angle in, IEEE-754 single cos out.
// One CORDIC micro-rotation per enabled clock; done pulses ITER+2 enabled edges after start.
// Ports:
//   clock  - rising-edge clock
//   aclr   - asynchronous active-high reset, aborts any operation in flight
//   clk_en - clock enable, freezes all state when low
//   start  - one-cycle request, samples dataa while idle
//   dataa  - angle in radians (|x| <= 1.0)
//   result - cos(dataa), valid with done and held until the next completion
//   done   - one-cycle completion pulse
module cordic_cos_iter
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = IterDefault,
  parameter int unsigned FRAC = FracDefault,
  parameter int unsigned IW   = IwDefault
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  state_e               state_q;
  logic [31:0]          operand_q;
  logic signed [IW-1:0] x_q, y_q, z_q;
  logic [IdxW-1:0]      iter_q;
  logic [31:0]          result_q;
  logic                 done_q;

  logic signed [IW-1:0] x_rot, y_rot, z_rot;
  logic signed [IW-1:0] z_load;
  logic [31:0]          norm_result;

  cordic_stage #(
    .IW(IW)
  ) u_stage (
    .x_i  (x_q),
    .y_i  (y_q),
    .z_i  (z_q),
    .idx_i(iter_q),
    .x_o  (x_rot),
    .y_o  (y_rot),
    .z_o  (z_rot)
  );

  // Float -> fixed of |operand|; the sign is dropped because cos is even.
  logic [7:0]  f_exp;
  logic [7:0]  exp_c;
  logic [23:0] f_sig;
  int          sh_in;

  always_comb begin
    f_exp  = operand_q[30:23];
    f_sig  = {1'b1, operand_q[22:0]};
    exp_c  = 8'd0;
    sh_in  = 0;
    z_load = '0;
    if (f_exp != 8'd0 && int'(f_exp) >= 127 - int'(FRAC)) begin
      // Magnitudes of 2.0 and above are out of range; clamp so the shift stays defined
      exp_c  = (f_exp > 8'd127) ? 8'd127 : f_exp;
      sh_in  = 150 - int'(FRAC) - int'(exp_c);
      z_load = IW'(f_sig >> sh_in);
    end
  end

  // Fixed -> float of x, treated as a non-negative magnitude.
  logic [IW-1:0] x_mag;
  logic [IW-1:0] x_norm;
  int            msb_pos;

  always_comb begin
    x_mag   = x_q;
    msb_pos = 0;
    for (int b = 0; b < int'(IW); b++) begin
      if (x_mag[b]) msb_pos = b;
    end
    // Shift the leading one up to the top bit; the 23 bits below it form the mantissa
    x_norm = x_mag << (int'(IW) - 1 - msb_pos);
    if (x_mag == '0) begin
      norm_result = 32'h0000_0000;
    end else begin
      norm_result = {1'b0, 8'(127 + msb_pos - int'(FRAC)), x_norm[IW-2 -: 23]};
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q   <= StIdle;
      operand_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else if (clk_en) begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            operand_q <= dataa;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          x_q     <= IW'(KConst);
          y_q     <= '0;
          z_q     <= z_load;
          iter_q  <= '0;
          state_q <= StRot;
        end
        StRot: begin
          x_q <= x_rot;
          y_q <= y_rot;
          z_q <= z_rot;
          if (iter_q == IdxW'(ITER - 1)) begin
            state_q <= StNorm;
          end else begin
            iter_q <= iter_q + IdxW'(1);
          end
        end
        StNorm: begin
          result_q <= norm_result;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Self-checking bench for cordic_cos_iter: table-driven angle sweep plus hand-written
// sequences for latency, clock-enable stalls, busy starts and asynchronous abort.
module tb_cordic_cos_iter;

  logic        clock = 1'b0;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  int  checks = 0;
  int  errors = 0;
  real exp_q[$];

  localparam real Tol = 1.0 / 32768.0;

  typedef struct {
    logic [31:0] a;
    real         ev;
  } vec_t;

  vec_t vecs[11];

  always #5 clock = ~clock;

  cordic_cos_iter dut (
    .clock (clock),
    .aclr  (aclr),
    .clk_en(clk_en),
    .start (start),
    .dataa (dataa),
    .result(result),
    .done  (done)
  );

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    m = m * (2.0 ** e);
    return b[31] ? -m : m;
  endfunction

  task automatic check_real(input string name, input logic [31:0] act, input real req);
    real v, d;
    checks++;
    v = f2r(act);
    d = v - req;
    if (d < 0.0) d = -d;
    if (d > Tol) begin
      errors++;
      $display("FAIL %s: got %h (%f) want %f +/- 2^-15", name, act, v, req);
    end
  endtask

  task automatic check_bits(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation. Called #1 after a rising edge. Optional clk_en stall
  // (stall_at/stall_len, in edges after the sampling edge) and a busy start at busy_at.
  task automatic do_op(input string name, input logic [31:0] a, input real ev,
                       input int stall_at, input int stall_len,
                       input logic [31:0] busy_a, input int busy_at,
                       output logic [31:0] res);
    int  first;
    int  pulses;
    real ev_pop;
    first  = -1;
    pulses = 0;
    res    = '0;
    dataa  = a;
    start  = 1'b1;
    exp_q.push_back(ev);
    tick();
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (done) begin
        pulses++;
        if (first < 0) begin
          first = n;
          res   = result;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_done: got done with empty queue want none", name);
          end else begin
            ev_pop = exp_q.pop_front();
            check_real(name, result, ev_pop);
          end
        end
      end
      if (n == stall_at) clk_en = 1'b0;
      if (n == stall_at + stall_len) clk_en = 1'b1;
      if (n == busy_at) begin
        start = 1'b1;
        dataa = busy_a;
      end else if (n == busy_at + 1) begin
        start = 1'b0;
      end
      if (first >= 0 && n == first + 2) break;
    end
    if (first < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done want done at %0d", name, 18 + stall_len);
      if (exp_q.size() > 0) ev_pop = exp_q.pop_front();
    end else begin
      check_int({name, "_latency"}, first, 18 + stall_len);
      check_int({name, "_pulses"}, pulses, 1);
    end
  endtask

  initial begin
    logic [31:0] res, res_pos, res_neg;
    int          seen;

    vecs[0]  = '{32'h00000000, 1.0000010};
    vecs[1]  = '{32'h3DCCCCCD, 0.9950027};
    vecs[2]  = '{32'h3E4CCCCD, 0.9800673};
    vecs[3]  = '{32'h3E99999A, 0.9553366};
    vecs[4]  = '{32'h3ECCCCCD, 0.9210587};
    vecs[5]  = '{32'h3F000000, 0.8775778};
    vecs[6]  = '{32'h3F19999A, 0.8253250};
    vecs[7]  = '{32'h3F333333, 0.7648296};
    vecs[8]  = '{32'h3F4CCCCD, 0.6967068};
    vecs[9]  = '{32'h3F666666, 0.6216106};
    vecs[10] = '{32'h3F800000, 0.5402956};

    aclr   = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'h0;
    repeat (3) tick();
    check_int("reset_done_held", int'(done), 0);
    aclr = 1'b0;
    tick();
    check_int("reset_done", int'(done), 0);
    check_bits("reset_result", result, 32'h00000000);

    // Angle sweep 0.0 .. 1.0
    for (int k = 0; k < 11; k++) begin
      do_op($sformatf("sweep%0d", k), vecs[k].a, vecs[k].ev, -1, 0, 32'h0, -1, res);
      if (k == 5) res_pos = res;
    end

    // Result holds while idle
    repeat (5) tick();
    check_real("result_held", result, 0.5402956);
    check_int("done_idle_low", int'(done), 0);

    // Clock-enable stall of 5 cycles mid-rotation
    do_op("clken_stall", 32'h3F800000, 0.5402956, 6, 5, 32'h0, -1, res);

    // Sign symmetry and denormal input
    do_op("neg_half", 32'hBF000000, 0.8775778, -1, 0, 32'h0, -1, res_neg);
    check_bits("sign_symmetry", res_neg, res_pos);
    do_op("denormal", 32'h00000001, 1.0000010, -1, 0, 32'h0, -1, res);

    // Start during rotation must be ignored
    do_op("busy_start", 32'h3F000000, 0.8775778, -1, 0, 32'h3F800000, 8, res);

    // Asynchronous abort mid-rotation: no done, result cleared
    dataa = 32'h3F000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    aclr = 1'b1;
    #1;
    check_bits("abort_result_async", result, 32'h00000000);
    repeat (2) tick();
    aclr = 1'b0;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done) seen++;
    end
    check_int("abort_no_done", seen, 0);
    check_bits("abort_result", result, 32'h00000000);

    // Back to normal operation after the abort
    do_op("after_abort", 32'h3F4CCCCD, 0.6967068, -1, 0, 32'h0, -1, res);

    check_int("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_cos_iter.md
Name: cordic_cos_iter

Overview:
- Cosine accelerator wrapped as a custom-instruction slave with a start/done handshake.
- Takes an IEEE-754 single-precision angle in radians, with |x| ≤ 1.0, on `dataa`.
- Computes cos(x) with a rotation-mode CORDIC. The datapath is rolled: one CORDIC micro-rotation per clock (unroll factor 1).
- Returns cos(x) as an IEEE-754 single on `result`, qualified by a one-cycle `done` pulse.

Parameters:
- ITER, 16, number of CORDIC micro-rotations (i = 0..ITER-1).
- FRAC, 22, fractional bits of the internal fixed-point format.
- IW, 26, internal signed word width (Q3.22: sign plus 3 integer bits).

Ports:
- clock  in  1  rising-edge clock.
- aclr  in  1  asynchronous active-high reset.
- clk_en  in  1  clock enable; when low, every register holds its value.
- start  in  1  one-cycle request; samples `dataa`.
- dataa  in  32  IEEE-754 single angle, radians.
- result  out  32  IEEE-754 single cos(dataa); valid when `done`=1, held afterwards.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: `aclr`=1 asynchronously clears all state. `result`=0, `done`=0, FSM in IDLE. The same applies mid-operation: the computation is aborted and no `done` is issued.
- All sequential updates are gated by `clk_en`. With `clk_en`=0 the FSM, counters, datapath and outputs are frozen, and `start` is ignored.
- FSM states:
  - IDLE:
    - `start`=1 → LOAD.
    - Capture `dataa`.
  - LOAD: float→fixed conversion.
    - Sign is ignored, since cos is even, so z0 = |x|.
    - e = exp − 127.
    - If exp = 0 (zero or denormal) or e < −FRAC, then z0 = 0.
    - Otherwise z0 = {1,mantissa} shifted to 22 fractional bits, truncated.
    - Inputs with |x| > 1, NaN or Inf are outside the contract; the output is don't-care but the FSM must still complete.
    - Set x0 = K = round(0.6072529350 × 2^22), y0 = 0, i = 0.
    - Next state is ROT.
  - ROT: one micro-rotation per cycle.
    - d = (z ≥ 0) ? +1 : −1.
    - x' = x − d·(y >>> i).
    - y' = y + d·(x >>> i).
    - z' = z − d·atan(2^−i).
    - Shifts are arithmetic; the atan constants come from the ROM and are rounded to FRAC bits.
    - After i = ITER−1 completes → NORM.
  - NORM: fixed→float of x.
    - x is positive for the valid domain.
    - Leading-one detect, normalise, exponent = 127 + (msb_pos − FRAC), mantissa truncated to 23 bits.
    - x = 0 → result 0x00000000.
    - Register `result`, assert `done` for exactly one cycle, then return to IDLE.
- Latency: `done` is high on the (ITER+2)th enabled rising edge after the edge that samples `start`. That is 18 cycles for ITER=16.
- `start` while not IDLE is ignored; there is no restart.
- `start` on the same edge that `done` is asserted is also ignored; the requester must wait for `done`.
- `result` keeps its last value until the next NORM or reset.
- Accuracy: |result − cos(x)| ≤ 2^−15 for all |x| ≤ 1. Output is never negative for the valid domain.

Decomposition:
- Package cordic_pkg holds:
  - FRAC, IW, ITER defaults.
  - K constant.
  - atan(2^−i) table, i = 0..23, in Q3.22.
  - FSM state enum.
- Sub-module cordic_stage: purely combinational single micro-rotation with inputs x, y, z, i and outputs x', y', z'. It is instantiated once.
- Float conversion stays in the top level.

Test Plan:
- Reset check: hold aclr=1, then release → done=0, result=0x00000000. Assert aclr mid-ROT → done never pulses and the FSM returns to IDLE.
- Single-pulse start on the sweep 0.0, 0.1, …, 1.0 (0x00000000, 0x3DCCCCCD, 0x3E4CCCCD, 0x3E99999A, 0x3ECCCCCD, 0x3F000000, 0x3F19999A, 0x3F333333, 0x3F4CCCCD, 0x3F666666, 0x3F800000). Required results within 2^−15 of: 1.0000010, 0.9950027, 0.9800673, 0.9553366, 0.9210587, 0.8775778, 0.8253250, 0.7648296, 0.6967068, 0.6216106, 0.5402956.
- Latency and pulse shape: start with dataa=0x3F000000 → done=1 exactly 18 cycles later for one cycle only. result ≈ 0x3F60A8xx, held afterwards.
- clk_en toggling: deassert clk_en for 5 cycles mid-ROT → done is delayed by exactly 5 cycles and result is unchanged (0x3F800000 input → ≈0x3F0A51xx).
- Sign and edge inputs: −0.5 (0xBF000000) gives the same result as +0.5. Denormal 0x00000001 → ≈1.0.
- Busy start: re-assert start with a new dataa during ROT → ignored; result still corresponds to the first operand.
